inst_fetch: RTL and testbench

Instruction-fetch requester that drives the instruction ROM's chip-enable/address port and captures the returned word. Holds the PC, steps it by 4 per fetch, and applies branch redirects from execute. Presents fetched {pc, inst} pairs to decode through a valid/ready register stage. The ROM is combinational: the word for `o_romAddr` is valid on `romInst` in the same cycle.

---
 rtl/inst_fetch_if.sv | 40 ++++
 rtl/inst_fetch.sv | 105 ++++++++++
 tb/tb_inst_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction ROM request/return, execute redirect,
// and the valid/ready hand-off to decode.
interface inst_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              o_romEnable;
   logic [ADDR_W-1:0] o_romAddr;
   logic [INST_W-1:0] romInst;
   logic              redirectValid;
   logic [ADDR_W-1:0] redirectAddr;
   logic              o_valid;
   logic [ADDR_W-1:0] o_pc;
   logic [INST_W-1:0] o_inst;
   logic              idReady;

   modport master (
      output o_romEnable,
      output o_romAddr,
      input  romInst,
      input  redirectValid,
      input  redirectAddr,
      output o_valid,
      output o_pc,
      output o_inst,
      input  idReady
   );

   modport slave (
      input  o_romEnable,
      input  o_romAddr,
      output romInst,
      output redirectValid,
      output redirectAddr,
      input  o_valid,
      input  o_pc,
      input  o_inst,
      output idReady
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch requester: PC sequencing, redirect handling and a small
// output queue to decode. FETCH_SKID_BUF_EN selects a 2-entry queue (default 1).
module inst_fetch #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst_n,
   inst_fetch_if.master  bus
);

`ifdef FETCH_SKID_BUF_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   logic              run_q, run_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]        count_q, count_d;
   logic [ADDR_W-1:0] head_pc_q, head_pc_d;
   logic [INST_W-1:0] head_inst_q, head_inst_d;
`ifdef FETCH_SKID_BUF_EN
   logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic [INST_W-1:0] skid_inst_q, skid_inst_d;
`endif

   logic              pop;
   logic              fetch;
   logic [1:0]        cnt_after_pop;

   // run_q keeps the ROM idle in the first cycle after reset is released
   always_comb begin
      pop           = (count_q != 2'd0) && bus.idReady;
      fetch         = run_q && !bus.redirectValid &&
                      ((count_q < DEPTH) || ((count_q == DEPTH) && bus.idReady));
      cnt_after_pop = count_q - {1'b0, pop};

      run_d       = 1'b1;
      pc_d        = pc_q;
      count_d     = cnt_after_pop + {1'b0, fetch};
      head_pc_d   = head_pc_q;
      head_inst_d = head_inst_q;
`ifdef FETCH_SKID_BUF_EN
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;
      if (pop) begin
         head_pc_d   = skid_pc_q;
         head_inst_d = skid_inst_q;
      end
`endif

      if (fetch) begin
         pc_d = pc_q + ADDR_W'(4);
         if (cnt_after_pop == 2'd0) begin
            head_pc_d   = pc_q;
            head_inst_d = bus.romInst;
         end
`ifdef FETCH_SKID_BUF_EN
         else begin
            skid_pc_d   = pc_q;
            skid_inst_d = bus.romInst;
         end
`endif
      end

      // a redirect discards everything queued; a same-cycle pop already happened
      if (bus.redirectValid) begin
         count_d = 2'd0;
         pc_d    = bus.redirectAddr & ~ADDR_W'(3);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q       <= 1'b0;
         pc_q        <= RESET_PC;
         count_q     <= 2'd0;
         head_pc_q   <= '0;
         head_inst_q <= '0;
`ifdef FETCH_SKID_BUF_EN
         skid_pc_q   <= '0;
         skid_inst_q <= '0;
`endif
      end else begin
         run_q       <= run_d;
         pc_q        <= pc_d;
         count_q     <= count_d;
         head_pc_q   <= head_pc_d;
         head_inst_q <= head_inst_d;
`ifdef FETCH_SKID_BUF_EN
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
`endif
      end
   end

   assign bus.o_romEnable = fetch;
   assign bus.o_romAddr   = pc_q;
   assign bus.o_valid     = (count_q != 2'd0);
   assign bus.o_pc        = head_pc_q;
   assign bus.o_inst      = head_inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: start-up, stall, redirect, reset and PC wrap.
module tb_inst_fetch;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst1_n;

   inst_fetch_if if0 ();
   inst_fetch_if if1 ();

   inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if0.master)
   );

   inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk   (clk),
      .rst_n (rst1_n),
      .bus   (if1.master)
   );

   // ROM word i holds 0x1000 + i
   assign if0.romInst = 32'h1000 + (if0.o_romAddr >> 2);
   assign if1.romInst = 32'h1000 + (if1.o_romAddr >> 2);

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst);
      chk({tag, "_valid"}, 64'(if0.o_valid), 64'(v));
      chk({tag, "_pc"},    64'(if0.o_pc),    64'(pc));
      chk({tag, "_inst"},  64'(if0.o_inst),  64'(inst));
   endtask

   initial begin
      rst_n = 1'b0;
      rst1_n = 1'b0;
      if0.idReady = 1'b1;
      if0.redirectValid = 1'b0;
      if0.redirectAddr = '0;
      if1.idReady = 1'b1;
      if1.redirectValid = 1'b0;
      if1.redirectAddr = '0;

      tick(); tick(); #2;
      chk_head("rst", 1'b0, 32'h0, 32'h0);
      chk("rst_en", 64'(if0.o_romEnable), 64'(0));

      rst_n = 1'b1;
      tick(); #2;
      chk("e0_en", 64'(if0.o_romEnable), 64'(1));
      chk("e0_addr", 64'(if0.o_romAddr), 64'h0);
      chk("e0_valid", 64'(if0.o_valid), 64'(0));

      tick(); #2;
      chk_head("seq0", 1'b1, 32'h0, 32'h1000);
      chk("seq0_addr", 64'(if0.o_romAddr), 64'h4);
      tick(); #2;
      chk_head("seq4", 1'b1, 32'h4, 32'h1001);

      tick(); if0.idReady = 1'b0; #2;
      chk_head("stall1", 1'b1, 32'h8, 32'h1002);
`ifdef FETCH_SKID_BUF_EN
      chk("stall1_en", 64'(if0.o_romEnable), 64'(1));
      chk("stall1_addr", 64'(if0.o_romAddr), 64'hC);
`else
      chk("stall1_en", 64'(if0.o_romEnable), 64'(0));
`endif
      tick(); #2;
      chk_head("stall2", 1'b1, 32'h8, 32'h1002);
      chk("stall2_en", 64'(if0.o_romEnable), 64'(0));
      tick(); #2;
      chk_head("stall3", 1'b1, 32'h8, 32'h1002);
      chk("stall3_en", 64'(if0.o_romEnable), 64'(0));

      tick(); if0.idReady = 1'b1; #2;
      chk_head("release", 1'b1, 32'h8, 32'h1002);
      chk("release_en", 64'(if0.o_romEnable), 64'(1));
`ifdef FETCH_SKID_BUF_EN
      chk("release_addr", 64'(if0.o_romAddr), 64'h10);
`else
      chk("release_addr", 64'(if0.o_romAddr), 64'hC);
`endif
      tick(); #2;
      chk_head("after12", 1'b1, 32'hC, 32'h1003);

      tick(); if0.redirectValid = 1'b1; if0.redirectAddr = 32'h40; #2;
      chk_head("redirN", 1'b1, 32'h10, 32'h1004);
      chk("redirN_en", 64'(if0.o_romEnable), 64'(0));
      tick(); if0.redirectValid = 1'b0; #2;
      chk("redirN1_valid", 64'(if0.o_valid), 64'(0));
      chk("redirN1_en", 64'(if0.o_romEnable), 64'(1));
      chk("redirN1_addr", 64'(if0.o_romAddr), 64'h40);

      tick(); if0.redirectValid = 1'b1; if0.redirectAddr = 32'h43; #2;
      chk_head("redirN2", 1'b1, 32'h40, 32'h1010);
      chk("unal_en", 64'(if0.o_romEnable), 64'(0));
      tick(); if0.redirectValid = 1'b0; #2;
      chk("unal1_valid", 64'(if0.o_valid), 64'(0));
      chk("unal1_addr", 64'(if0.o_romAddr), 64'h40);
      tick(); #2;
      chk_head("unal2", 1'b1, 32'h40, 32'h1010);

      tick(); if0.idReady = 1'b0; #2;
      chk_head("fstall1", 1'b1, 32'h44, 32'h1011);
      tick(); #2;
      chk_head("fstall2", 1'b1, 32'h44, 32'h1011);
      tick(); if0.redirectValid = 1'b1; if0.redirectAddr = 32'h80; #2;
      chk_head("fstall3", 1'b1, 32'h44, 32'h1011);
      chk("fstall3_en", 64'(if0.o_romEnable), 64'(0));
      tick(); if0.redirectValid = 1'b0; if0.idReady = 1'b1; #2;
      chk("fredir1_valid", 64'(if0.o_valid), 64'(0));
      chk("fredir1_addr", 64'(if0.o_romAddr), 64'h80);
      tick(); #2;
      chk_head("fredir2", 1'b1, 32'h80, 32'h1020);

      tick(); rst_n = 1'b0; #2;
      chk_head("prerst", 1'b1, 32'h84, 32'h1021);
      tick(); #2;
      chk_head("midrst", 1'b0, 32'h0, 32'h0);
      chk("midrst_en", 64'(if0.o_romEnable), 64'(0));
      rst_n = 1'b1;
      tick(); #2;
      chk("restart_en", 64'(if0.o_romEnable), 64'(1));
      chk("restart_addr", 64'(if0.o_romAddr), 64'h0);
      tick(); #2;
      chk_head("restart0", 1'b1, 32'h0, 32'h1000);

      rst1_n = 1'b1;
      tick(); #2;
      chk("wrap_addr", 64'(if1.o_romAddr), 64'hFFFF_FFFC);
      tick(); #2;
      chk("wrap_pc0", 64'(if1.o_pc), 64'hFFFF_FFFC);
      chk("wrap_v0", 64'(if1.o_valid), 64'(1));
      tick(); #2;
      chk("wrap_pc1", 64'(if1.o_pc), 64'h0);
      chk("wrap_inst1", 64'(if1.o_inst), 64'h1000);
      tick(); #2;
      chk("wrap_pc2", 64'(if1.o_pc), 64'h4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
